// File: rtl/oscilo_pkg.sv
// Shared definitions for the oscilloscope capture path: command codes, frame constants
// and the sample read-out FSM state encoding.
package oscilo_pkg;

    localparam logic [7:0] CMD_SAMPLE_READ = 8'h22;
    localparam logic [7:0] FRAME_HEADER    = 8'hA5;

    typedef enum logic [3:0] {
        StIdle,
        StHdr,
        StCnt,
        StFetch,
        StLatch,
        StSend,
        StWaitTx,
        StCsum,
        StFin,
        StAbort
    } sample_streamer_state_t;

endpackage

// File: rtl/sample_streamer.sv
// Sample read-out stage: frames the captured buffer as HEADER, COUNT, samples, CHECKSUM
// and streams it one byte at a time through uart_tx.
module sample_streamer
    import oscilo_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned SAMPLE_COUNT = 256,
    parameter logic [7:0]  HEADER       = FRAME_HEADER
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  activate,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_oe,
    input  logic [DATA_WIDTH-1:0] mem_data,
    output logic [7:0]            tx_data,
    output logic                  tx_start,
    input  logic                  tx_active,
    input  logic                  tx_done
);

    localparam logic [ADDR_WIDTH-1:0] LAST_INDEX = ADDR_WIDTH'(SAMPLE_COUNT - 1);
    localparam logic [7:0]            COUNT_BYTE = 8'(SAMPLE_COUNT - 1);

    sample_streamer_state_t state_q, state_d;
    sample_streamer_state_t ret_q, ret_d;   // emission state whose byte is in flight
    logic [ADDR_WIDTH-1:0]  index_q, index_d;
    logic [ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [7:0]             checksum_q, checksum_d;
    logic [7:0]             sample_q, sample_d;
    logic [7:0]             tx_data_q, tx_data_d;
    logic                   tx_start_q, tx_start_d;
    logic                   mem_oe_q, mem_oe_d;
    logic                   done_q, done_d;
    logic [7:0]             emit_byte;

    always_comb begin
        case (state_q)
            StHdr:   emit_byte = HEADER;
            StCnt:   emit_byte = COUNT_BYTE;
            StSend:  emit_byte = sample_q;
            StCsum:  emit_byte = checksum_q;
            default: emit_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        index_d    = index_q;
        mem_addr_d = mem_addr_q;
        checksum_d = checksum_q;
        sample_d   = sample_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        mem_oe_d   = mem_oe_q;
        done_d     = done_q;

        case (state_q)
            StIdle: begin
                tx_data_d = 8'h00;
                mem_oe_d  = 1'b0;
                if (activate) begin
                    state_d    = StHdr;
                    checksum_d = 8'h00;
                    index_d    = '0;
                end
            end
            StHdr, StCnt, StSend, StCsum: begin
                if (!activate) begin
                    state_d   = StIdle;
                    tx_data_d = 8'h00;
                end else if (!tx_active) begin
                    tx_data_d  = emit_byte;
                    tx_start_d = 1'b1;
                    ret_d      = state_q;
                    state_d    = StWaitTx;
                end
            end
            StWaitTx: begin
                if (tx_done) begin
                    tx_data_d = 8'h00;
                    if (!activate) begin
                        state_d = StIdle;
                    end else begin
                        case (ret_q)
                            StHdr: state_d = StCnt;
                            StCnt: state_d = StFetch;
                            StSend: begin
                                if (index_q == LAST_INDEX) begin
                                    state_d = StCsum;
                                end else begin
                                    index_d = index_q + ADDR_WIDTH'(1);
                                    state_d = StFetch;
                                end
                            end
                            StCsum: begin
                                state_d = StFin;
                                done_d  = 1'b1;
                            end
                            default: state_d = StIdle;
                        endcase
                    end
                end else if (!activate) begin
                    state_d = StAbort;
                end
            end
            StFetch: begin
                if (!activate) begin
                    state_d = StIdle;
                end else begin
                    mem_addr_d = index_q;
                    mem_oe_d   = 1'b1;
                    state_d    = StLatch;
                end
            end
            StLatch: begin
                mem_oe_d = 1'b0;
                if (!activate) begin
                    state_d = StIdle;
                end else begin
                    sample_d   = mem_data;
                    checksum_d = checksum_q + mem_data;
                    state_d    = StSend;
                end
            end
            StFin: begin
                if (!activate) begin
                    done_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StAbort: begin
                // Keep the in-flight byte on the shared bus until the UART finishes it.
                if (tx_done) begin
                    tx_data_d = 8'h00;
                    state_d   = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= StIdle;
            ret_q      <= StIdle;
            index_q    <= '0;
            mem_addr_q <= '0;
            checksum_q <= 8'h00;
            sample_q   <= 8'h00;
            tx_data_q  <= 8'h00;
            tx_start_q <= 1'b0;
            mem_oe_q   <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            index_q    <= index_d;
            mem_addr_q <= mem_addr_d;
            checksum_q <= checksum_d;
            sample_q   <= sample_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            mem_oe_q   <= mem_oe_d;
            done_q     <= done_d;
        end
    end

    assign done     = done_q;
    assign mem_addr = mem_addr_q;
    assign mem_oe   = mem_oe_q;
    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;

endmodule

// File: tb/tb_sample_streamer.sv
// Scoreboard bench for sample_streamer: a 256-sample and a 4-sample instance, each with a
// behavioural UART and sample memory; expected frames are computed from the memory contents.
module tb_sample_streamer;

    localparam int unsigned N_BIG   = 256;
    localparam int unsigned N_SMALL = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // 256-sample instance
    logic       activate  = 1'b0;
    logic       uart_busy = 1'b0;
    logic       ext_busy  = 1'b0;
    logic       tx_done   = 1'b0;
    logic       tx_active;
    logic       done, mem_oe, tx_start;
    logic [7:0] mem_addr, mem_data, tx_data;
    logic [7:0] mem [N_BIG];
    logic [7:0] exp_q [$];
    int         starts = 0;
    int         cnt    = 0;

    assign tx_active = uart_busy | ext_busy;
    assign mem_data  = mem_oe ? mem[mem_addr] : 8'h00;

    sample_streamer #(.SAMPLE_COUNT(N_BIG)) u_dut (
        .clk      (clk),
        .reset    (reset),
        .activate (activate),
        .done     (done),
        .mem_addr (mem_addr),
        .mem_oe   (mem_oe),
        .mem_data (mem_data),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_active(tx_active),
        .tx_done  (tx_done)
    );

    // 4-sample instance
    logic       act_s    = 1'b0;
    logic       busy_s   = 1'b0;
    logic       txdn_s   = 1'b0;
    logic       done_s, oe_s, txs_s;
    logic [7:0] addr_s, mdata_s, txd_s;
    logic [7:0] mem_s [N_SMALL];
    logic [7:0] exp_s [$];
    int         cnt_s  = 0;

    assign mdata_s = oe_s ? mem_s[addr_s[1:0]] : 8'h00;

    sample_streamer #(.SAMPLE_COUNT(N_SMALL)) u_dut_s (
        .clk      (clk),
        .reset    (reset),
        .activate (act_s),
        .done     (done_s),
        .mem_addr (addr_s),
        .mem_oe   (oe_s),
        .mem_data (mdata_s),
        .tx_data  (txd_s),
        .tx_start (txs_s),
        .tx_active(busy_s),
        .tx_done  (txdn_s)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic push_frame();
        int sum = 0;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(N_BIG - 1));
        for (int i = 0; i < N_BIG; i++) begin
            exp_q.push_back(mem[i]);
            sum += int'(mem[i]);
        end
        exp_q.push_back(8'(sum % 256));
    endtask

    task automatic push_frame_s();
        int sum = 0;
        exp_s.push_back(8'hA5);
        exp_s.push_back(8'(N_SMALL - 1));
        for (int i = 0; i < N_SMALL; i++) begin
            exp_s.push_back(mem_s[i]);
            sum += int'(mem_s[i]);
        end
        exp_s.push_back(8'(sum % 256));
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input string name);
        int k = 0;
        while (done !== 1'b1 && k < 20000) begin
            tick();
            k++;
        end
        check(name, done, 1);
        check({name, " all bytes sent"}, exp_q.size(), 0);
    endtask

    // Behavioural UART models: busy for a random number of cycles, then a tx_done pulse.
    initial forever begin
        @(negedge clk);
        tx_done = 1'b0;
        if (!reset) begin
            uart_busy = 1'b0;
            cnt = 0;
        end else if (uart_busy) begin
            cnt--;
            if (cnt == 0) begin
                uart_busy = 1'b0;
                tx_done   = 1'b1;
            end
        end else if (tx_start === 1'b1) begin
            cnt = int'($urandom_range(3, 10));
            uart_busy = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        txdn_s = 1'b0;
        if (!reset) begin
            busy_s = 1'b0;
            cnt_s = 0;
        end else if (busy_s) begin
            cnt_s--;
            if (cnt_s == 0) begin
                busy_s = 1'b0;
                txdn_s = 1'b1;
            end
        end else if (txs_s === 1'b1) begin
            cnt_s = int'($urandom_range(2, 6));
            busy_s = 1'b1;
        end
    end

    // Monitors: every tx_start pops one expected byte.
    initial forever begin
        @(negedge clk);
        if (tx_start === 1'b1) begin
            starts++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected tx_start: got byte %02h, required no start", tx_data);
            end else begin
                check("tx byte", tx_data, exp_q.pop_front());
            end
        end
        if (uart_busy && tx_start === 1'b0 && tx_data === 8'h00 && exp_q.size() != 0
            && activate) begin
            // A zero byte is legal data; only flag the bus dropping to zero when it had
            // carried a nonzero byte is not tracked here.
        end
    end

    initial forever begin
        @(negedge clk);
        if (txs_s === 1'b1) begin
            if (exp_s.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected tx_start small: got byte %02h, required no start",
                         txd_s);
            end else begin
                check("small tx byte", txd_s, exp_s.pop_front());
            end
        end
    end

    initial begin
        int base;
        int k;
        for (int i = 0; i < N_BIG; i++) mem[i] = 8'(i);

        #5 reset = 1'b0;
        repeat (3) tick();
        check("reset done", done, 0);
        check("reset tx_start", tx_start, 0);
        check("reset tx_data", tx_data, 0);
        check("reset mem_oe", mem_oe, 0);
        check("reset mem_addr", mem_addr, 0);
        reset = 1'b1;
        tick();

        // Ramp memory: A5, FF, 00..FF, 80
        push_frame();
        activate = 1'b1;
        wait_done("ramp frame done");

        // done held while activate stays high; bus idle in the meantime
        for (int i = 0; i < 50; i++) begin
            tick();
            check("done held / bus idle", {done, tx_start, tx_data}, 10'h200);
        end
        activate = 1'b0;
        tick();
        check("done falls after activate", done, 0);

        // Small instance: fixed wrap case, then random contents
        for (int r = 0; r < 6; r++) begin
            if (r == 0) begin
                mem_s[0] = 8'hFF; mem_s[1] = 8'hFF; mem_s[2] = 8'h01; mem_s[3] = 8'h02;
            end else begin
                for (int i = 0; i < N_SMALL; i++) mem_s[i] = 8'($urandom);
            end
            push_frame_s();
            act_s = 1'b1;
            k = 0;
            while (done_s !== 1'b1 && k < 2000) begin
                tick();
                k++;
            end
            check("small frame done", done_s, 1);
            check("small all bytes sent", exp_s.size(), 0);
            act_s = 1'b0;
            tick();
            check("small done falls", done_s, 0);
        end

        // Abort during sample 10 (frame byte 12) stop bit, then a full frame from the header
        for (int i = 0; i < N_BIG; i++) mem[i] = 8'($urandom);
        push_frame();
        base = starts;
        activate = 1'b1;
        k = 0;
        while (!(starts >= base + 13 && uart_busy && cnt == 1) && k < 5000) begin
            tick();
            k++;
        end
        check("reached sample 10 stop bit", starts - base, 13);
        activate = 1'b0;
        exp_q.delete();
        base = starts;
        k = 0;
        while (tx_done !== 1'b1 && k < 50) begin
            tick();
            k++;
        end
        check("abort tx_done seen", tx_done, 1);
        tick();
        check("abort bus released", {done, mem_oe, tx_start, tx_data}, 0);
        repeat (30) tick();
        check("no start after abort", starts - base, 0);
        check("no done after abort", done, 0);
        push_frame();
        activate = 1'b1;
        wait_done("frame after abort");
        activate = 1'b0;
        tick();

        // External UART busy before the job: nothing may start until it clears
        for (int i = 0; i < N_BIG; i++) mem[i] = 8'($urandom);
        ext_busy = 1'b1;
        push_frame();
        base = starts;
        activate = 1'b1;
        repeat (100) tick();
        check("no start while tx_active", starts - base, 0);
        ext_busy = 1'b0;
        wait_done("frame after busy");
        activate = 1'b0;
        tick();

        // Asynchronous reset while a memory read is pending
        for (int i = 0; i < N_BIG; i++) mem[i] = 8'($urandom);
        push_frame();
        base = starts;
        activate = 1'b1;
        k = 0;
        while (!(starts >= base + 20 && mem_oe === 1'b1) && k < 5000) begin
            tick();
            k++;
        end
        check("read pending before reset", mem_oe, 1);
        @(negedge clk);
        #3 reset = 1'b0;
        #1;
        check("async reset outputs", {done, mem_oe, tx_start, tx_data, mem_addr}, 0);
        exp_q.delete();
        activate = 1'b0;
        tick();
        reset = 1'b1;
        tick();

        // Recovery: a fresh random frame
        for (int i = 0; i < N_BIG; i++) mem[i] = 8'($urandom);
        push_frame();
        activate = 1'b1;
        wait_done("frame after reset");
        activate = 1'b0;
        tick();
        check("final done low", done, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
